// File: rtl/video_tpg_pkg.sv
// video_tpg_pkg: shared types and constants for the colour-bar test pattern
// generator.
//   tpg_state_e    - FSM state encoding (IDLE / ACTIVE)
//   COL_*          - the eight 24-bit bar colours, {R,G,B} MSB to LSB
//   bar_color()    - maps a bar index 0..7 to its 24-bit colour
package video_tpg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } tpg_state_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_tpg_cnt.sv
// video_tpg_cnt: x/y position of the pixel currently presented on the bus.
//   clk, rst     - clock, synchronous active-high reset (position -> 0,0)
//   adv          - advance to the next pixel (a beat transferred this cycle)
//   x, y         - current position
//   x_nxt, y_nxt - position after the current one, with line/frame wrap
//   line_end     - current pixel is the last of its line
//   frame_end    - current pixel is the last of the frame
module video_tpg_cnt #(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48,
  parameter int XW       = 6,
  parameter int YW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [XW-1:0] x_nxt,
  output logic [YW-1:0] y_nxt,
  output logic          line_end,
  output logic          frame_end
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_line;

  always_comb begin
    line_end  = (x_q == XW'(H_ACTIVE - 1));
    last_line = (y_q == YW'(V_ACTIVE - 1));
    frame_end = line_end && last_line;
    x_nxt     = line_end ? '0 : x_q + 1'b1;
    y_nxt     = y_q;
    if (line_end) begin
      y_nxt = last_line ? '0 : y_q + 1'b1;
    end
    x_d = adv ? x_nxt : x_q;
    y_d = adv ? y_nxt : y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/video_tpg.sv
// video_tpg: eight-bar colour test pattern on an AXI4-Stream master.
//   clk, rst       - clock, synchronous active-high reset
//   en             - generation enable, only acted on while idle or at frame end
//   m_axis_tdata   - pixel {R,G,B}, each component all-ones or zero
//   m_axis_tvalid  - beat valid (registered, independent of tready)
//   m_axis_tready  - sink ready
//   m_axis_tuser   - start of frame (pixel 0,0)
//   m_axis_tlast   - end of line (x = H_ACTIVE-1)
//   m_axis_tstrb/tkeep/tid/tdest - constants
//
// state  | meaning
// IDLE   | no frame in progress, tvalid low, waiting for en
// ACTIVE | frame in progress, tvalid high, pixel held until accepted
module video_tpg
  import video_tpg_pkg::*;
#(
  parameter int DATAW    = 24,
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [DATAW-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic [DATAW/8-1:0] m_axis_tstrb,
  output logic [DATAW/8-1:0] m_axis_tkeep,
  output logic               m_axis_tid,
  output logic               m_axis_tdest
);

  localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;

  tpg_state_e       state_q, state_d;
  logic             tvalid_q, tvalid_d;
  logic             tuser_q, tuser_d;
  logic             tlast_q, tlast_d;
  logic [DATAW-1:0] tdata_q, tdata_d;

  logic             adv;
  logic [XW-1:0]    x_cur, x_nxt;
  logic [YW-1:0]    y_cur, y_nxt;
  logic             line_end, frame_end;

  video_tpg_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .x         (x_cur),
    .y         (y_cur),
    .x_nxt     (x_nxt),
    .y_nxt     (y_nxt),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  function automatic logic [DATAW-1:0] bar_pixel(input logic [XW-1:0] xv);
    logic [2:0] idx;
    idx = 3'(xv / XW'(BAR_W));
    return {(DATAW/24){bar_color(idx)}};
  endfunction

  // Outputs are loaded with the pixel that will be on the bus next cycle:
  // the current position when starting from IDLE, the next position after
  // an accepted beat. Without a transfer everything holds.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    adv      = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d  = ACTIVE;
          tvalid_d = 1'b1;
          tdata_d  = bar_pixel(x_cur);
          tuser_d  = (x_cur == '0) && (y_cur == '0);
          tlast_d  = line_end;
        end
      end
      ACTIVE: begin
        if (m_axis_tready) begin
          adv = 1'b1;
          if (frame_end && !en) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            tdata_d = bar_pixel(x_nxt);
            tuser_d = (x_nxt == '0) && (y_nxt == '0);
            tlast_d = (x_nxt == XW'(H_ACTIVE - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tstrb  = '1;
  assign m_axis_tkeep  = '1;
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;

endmodule

// File: tb/tb_video_tpg.sv
// tb_video_tpg: directed self-checking bench for video_tpg at default
// parameters (24-bit pixels, 64x48 frame).
module tb_video_tpg;

  localparam int DATAW = 24;
  localparam int H     = 64;
  localparam int V     = 48;
  localparam int FRAME = H * V;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             tready;
  logic [DATAW-1:0] tdata;
  logic             tvalid;
  logic             tuser;
  logic             tlast;
  logic [2:0]       tstrb;
  logic [2:0]       tkeep;
  logic             tid;
  logic             tdest;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  video_tpg #(.DATAW(DATAW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .m_axis_tstrb  (tstrb),
    .m_axis_tkeep  (tkeep),
    .m_axis_tid    (tid),
    .m_axis_tdest  (tdest)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (pos %0d, t=%0t)", tag, got, exp, pos, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int p);
    return bar_rgb[(p % H) / 8];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, tvalid, 1'b0);
    check({tag, "_tdata"},  tdata,  '0);
    check({tag, "_tuser"},  tuser,  1'b0);
    check({tag, "_tlast"},  tlast,  1'b0);
    check({tag, "_tstrb"},  tstrb,  3'h7);
    check({tag, "_tkeep"},  tkeep,  3'h7);
    check({tag, "_tid"},    tid,    1'b0);
    check({tag, "_tdest"},  tdest,  1'b0);
  endtask

  // Runs at negedges: checks the presented beat against the frame-position
  // model, drives tready for the coming edge, and advances the model on a
  // transfer. mode 0: ready always high; mode 1: 4 cycles high, 1 low.
  // drop_at >= 0 drops en once the model reaches that frame position.
  task automatic stream(input int n, input int mode, input int drop_at);
    int done;
    int cyc;
    int limit;
    done  = 0;
    cyc   = 0;
    limit = n * 2 + 50;
    while (done < n && cyc < limit) begin
      if (tvalid) begin
        check("tdata", tdata, exp_pix(pos));
        check("tuser", tuser, (pos == 0));
        check("tlast", tlast, ((pos % H) == H - 1));
      end
      tready = (mode == 0) ? 1'b1 : ((cyc % 5) != 4);
      if (drop_at >= 0 && pos == drop_at) en = 1'b0;
      if (tvalid && tready) begin
        pos = (pos + 1) % FRAME;
        done++;
      end
      cyc++;
      @(negedge clk);
    end
    check("stream_beats", done, n);
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("idle_tvalid", tvalid, 1'b0);
      check("idle_tdata",  tdata,  '0);
    end

    // Start with the sink stalled: first pixel must appear and hold.
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("stall_tvalid", tvalid, 1'b1);
      check("stall_tuser",  tuser,  1'b1);
      check("stall_tdata",  tdata,  24'hFFFFFF);
      check("stall_tlast",  tlast,  1'b0);
      @(negedge clk);
    end

    // Full frame back to back, then first beat of the next frame.
    stream(FRAME + 1, 0, -1);
    // Rest of that frame and one more under a 4-high/1-low ready pattern.
    stream(FRAME - 1, 1, -1);
    check("frame_aligned", pos, 0);
    stream(FRAME, 1, -1);

    // Drop en at line 10: frame must finish, then go idle.
    stream(FRAME, 0, 10 * H);
    for (int i = 0; i < 10; i++) begin
      check("after_drop_tvalid", tvalid, 1'b0);
      check("after_drop_tuser",  tuser,  1'b0);
      @(negedge clk);
    end

    // Reset in the middle of a frame at pixel (20,5).
    en = 1'b1;
    stream(5 * H + 20, 0, -1);
    check("mid_tvalid", tvalid, 1'b1);
    check("mid_tdata",  tdata,  24'h00FFFF);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    pos = 0;
    @(negedge clk);
    check("restart_tvalid", tvalid, 1'b1);
    check("restart_tuser",  tuser,  1'b1);
    check("restart_tdata",  tdata,  24'hFFFFFF);
    stream(2 * H, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
